lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Memory stage of the rvseed core. Sits directly downstream of EXU and consumes its done pulse, ALU result, store data and control flags.
- Performs aligned loads and stores over a req/gnt/rvalid data-memory bus.
- Forms the write-back beat: reg write enable, address and data, plus a done pulse.
- Stalls upstream with mem_busy while a bus transaction is outstanding.

Parameters:
- CPU_WIDTH, 32, datapath / address width.
- REG_ADDR_WIDTH, 5, register index width.
- MEM_OP_WIDTH, 3, memory opcode width (funct3 encoding).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active low
- enable  in  1  rvseed enable; low blocks acceptance of new instructions
- exu_done_en  in  1  one-cycle pulse: EXU result valid
- exu_inst_pc  in  CPU_WIDTH  PC of the instruction
- exu_alu_res  in  CPU_WIDTH  ALU result; memory address for load/store
- exu_reg2_rdata  in  CPU_WIDTH  store data
- exu_inst_reg_wen  in  1  register write enable
- exu_inst_reg_waddr  in  REG_ADDR_WIDTH  destination register
- exu_inst_mem_wen  in  1  store
- exu_inst_mem_ren  in  1  load
- exu_inst_mem2reg  in  1  write-back selects load data
- exu_inst_mem_op  in  MEM_OP_WIDTH  size/sign opcode
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  CPU_WIDTH  word-aligned address (low two bits 0)
- dmem_wdata  out  CPU_WIDTH  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  CPU_WIDTH  read data
- mem_done_en  out  1  one-cycle write-back pulse
- mem_inst_pc  out  CPU_WIDTH  PC of the completing instruction
- mem_reg_wen  out  1  register write enable
- mem_reg_waddr  out  REG_ADDR_WIDTH  destination register
- mem_reg_wdata  out  CPU_WIDTH  write-back data
- mem_misalign  out  1  one-cycle pulse: misaligned access dropped
- mem_busy  out  1  stage occupied; upstream must hold

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- FSM states: IDLE, REQ, RWAIT.
  - IDLE: accepts when exu_done_en & enable; latches all exu_* inputs.
    - Non-memory instruction: stays IDLE; mem_done_en next cycle; wdata = alu_res.
    - Load or store, aligned: goes to REQ.
  - REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt is sampled high.
    - Store: gnt -> IDLE; mem_done_en next cycle; mem_reg_wen=0.
    - Load: gnt -> RWAIT; req deasserted.
  - RWAIT: on dmem_rvalid -> IDLE; mem_done_en next cycle with extracted load data.
- mem_busy = (state != IDLE). An exu_done_en arriving while busy is ignored; upstream guarantees it holds the instruction.
- Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - On a misaligned access: no bus request; mem_done_en and mem_misalign pulse together next cycle; mem_reg_wen=0.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; byte replicated x4.
  - SH: be = 0011 or 1100; half replicated x2.
  - SW: be = 1111.
- Load extract:
  - Byte/half selected by addr[1:0] from the latched address.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
- mem_reg_wen = latched reg_wen & (waddr != 0).
- mem_reg_wdata = extracted load data when mem2reg, else alu_res.
- Illegal mem_op (011, 11x): treated as misaligned (dropped, flagged).
- enable low: no new accepts; an in-flight transaction still completes.
- rvalid in the same cycle as gnt is not legal bus behaviour; rvalid is only sampled in RWAIT.
- Reset mid-transaction: FSM returns to IDLE and req drops immediately (async). Any rvalid that arrives later is ignored.
- Latency: non-memory 1 cycle; store 1 + gnt wait; load 2 + gnt wait + rvalid wait.

Decomposition:
- Shared package/define file:
  - MEM_OP codes: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
  - FSM state encodings.
  - CPU_WIDTH, REG_ADDR_WIDTH, MEM_OP_WIDTH.
- One combinational sub-module, lsu_align: store lane/BE generation, load extract/extend, misalign detect.
- FSM, input latch and write-back register stay in the top.

Test Plan:
- ALU op: exu_done_en, alu_res=0x1234, reg_wen=1, waddr=5, mem2reg=0 -> next cycle mem_done_en=1, waddr=5, wdata=0x1234, no dmem_req.
- SB to 0x103, data 0xA5: with gnt delayed 3 cycles, req held stable with addr=0x100, be=1000, wdata=0xA5A5A5A5 -> done 1 cycle after gnt, reg_wen=0.
- LB from 0x102, rdata=0x00800000 -> wdata=0xFFFFFF80. Repeat as LBU -> 0x00000080. Repeat as LHU from 0x102 with rdata=0x80010000 -> 0x00008001.
- LW from 0x102 -> mem_misalign=1 with done, no dmem_req, reg_wen=0. Load to x0 -> reg_wen=0.
- Second exu_done_en during RWAIT -> ignored, mem_busy=1; completion reflects the first instruction only.
- rst_n low during REQ -> dmem_req=0 immediately, outputs 0; a following rvalid produces no mem_done_en.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared widths, memory opcodes, FSM encoding and latched-instruction payload
// for the rvseed memory stage.
package lsu_mem_stage_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned MEM_OP_WIDTH   = 3;
  localparam int unsigned BE_WIDTH       = CPU_WIDTH / 8;
  localparam int unsigned OFF_WIDTH      = $clog2(BE_WIDTH);

  // funct3 encoding; stores reuse the B/H/W codes
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_B  = 3'b000;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_H  = 3'b001;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_W  = 3'b010;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_BU = 3'b100;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_RWAIT = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      pc;
    logic [CPU_WIDTH-1:0]      alu_res;
    logic                      reg_wen;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr;
    logic                      mem2reg;
    logic                      is_store;
    logic [MEM_OP_WIDTH-1:0]   mem_op;
  } lsu_inst_t;

  // 011, 110 and 111 have no load/store meaning
  function automatic logic mem_op_illegal(input logic [MEM_OP_WIDTH-1:0] op);
    return (op[1:0] == 2'b11) || (op[2] && op[1]);
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store byte-enables/replication, misalign detect,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] acc_op_i,
  input  logic [OFF_WIDTH-1:0]    acc_off_i,
  input  logic [CPU_WIDTH-1:0]    st_data_i,
  output logic                    acc_misalign_c_o,
  output logic [BE_WIDTH-1:0]     st_be_c_o,
  output logic [CPU_WIDTH-1:0]    st_wdata_c_o,
  input  logic [MEM_OP_WIDTH-1:0] ld_op_i,
  input  logic [OFF_WIDTH-1:0]    ld_off_i,
  input  logic [CPU_WIDTH-1:0]    ld_rdata_i,
  output logic [CPU_WIDTH-1:0]    ld_data_c_o
);

  logic [1:0]  acc_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    acc_size         = acc_op_i[1:0];
    acc_misalign_c_o = mem_op_illegal(acc_op_i)
                     || ((acc_size == 2'b01) && acc_off_i[0])
                     || ((acc_size == 2'b10) && (acc_off_i != '0));
    st_be_c_o    = '1;
    st_wdata_c_o = st_data_i;
    case (acc_size)
      2'b00: begin
        st_be_c_o    = BE_WIDTH'(1) << acc_off_i;
        st_wdata_c_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_c_o    = acc_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_c_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_op_i)
      MEM_OP_B:  ld_data_c_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_H:  ld_data_c_o = {{16{ld_half[15]}}, ld_half};
      MEM_OP_BU: ld_data_c_o = {24'b0, ld_byte};
      MEM_OP_HU: ld_data_c_o = {16'b0, ld_half};
      MEM_OP_W:  ld_data_c_o = ld_rdata_i;
      default:   ld_data_c_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rvseed memory stage: latches an EXU result, runs one aligned req/gnt/rvalid
// data-memory access when needed, and emits a registered write-back beat.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      exu_done_en,
  input  logic [CPU_WIDTH-1:0]      exu_inst_pc,
  input  logic [CPU_WIDTH-1:0]      exu_alu_res,
  input  logic [CPU_WIDTH-1:0]      exu_reg2_rdata,
  input  logic                      exu_inst_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] exu_inst_reg_waddr,
  input  logic                      exu_inst_mem_wen,
  input  logic                      exu_inst_mem_ren,
  input  logic                      exu_inst_mem2reg,
  input  logic [MEM_OP_WIDTH-1:0]   exu_inst_mem_op,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [CPU_WIDTH-1:0]      dmem_addr,
  output logic [CPU_WIDTH-1:0]      dmem_wdata,
  output logic [BE_WIDTH-1:0]       dmem_be,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [CPU_WIDTH-1:0]      dmem_rdata,
  output logic                      mem_done_en,
  output logic [CPU_WIDTH-1:0]      mem_inst_pc,
  output logic                      mem_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] mem_reg_waddr,
  output logic [CPU_WIDTH-1:0]      mem_reg_wdata,
  output logic                      mem_misalign,
  output logic                      mem_busy
);

  lsu_state_e                state_q, state_d;
  lsu_inst_t                 inst_q, inst_d;
  logic                      req_q, req_d, we_q, we_d;
  logic [CPU_WIDTH-1:0]      addr_q, addr_d, bwdata_q, bwdata_d;
  logic [BE_WIDTH-1:0]       be_q, be_d;
  logic                      done_q, done_d, mis_q, mis_d, busy_q, busy_d;
  logic [CPU_WIDTH-1:0]      wb_pc_q, wb_pc_d, wb_wdata_q, wb_wdata_d;
  logic                      wb_wen_q, wb_wen_d;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_q, wb_waddr_d;
  logic                      accept, is_mem, acc_misalign;
  logic [BE_WIDTH-1:0]       st_be;
  logic [CPU_WIDTH-1:0]      st_wdata, ld_data;

  lsu_align u_align (
    .acc_op_i         (exu_inst_mem_op),
    .acc_off_i        (exu_alu_res[OFF_WIDTH-1:0]),
    .st_data_i        (exu_reg2_rdata),
    .acc_misalign_c_o (acc_misalign),
    .st_be_c_o        (st_be),
    .st_wdata_c_o     (st_wdata),
    .ld_op_i          (inst_q.mem_op),
    .ld_off_i         (inst_q.alu_res[OFF_WIDTH-1:0]),
    .ld_rdata_i       (dmem_rdata),
    .ld_data_c_o      (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    bwdata_d   = bwdata_q;
    be_d       = be_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    wb_pc_d    = wb_pc_q;
    wb_wen_d   = wb_wen_q;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    accept     = (state_q == ST_IDLE) && exu_done_en && enable;
    is_mem     = exu_inst_mem_wen || exu_inst_mem_ren;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          inst_d.pc        = exu_inst_pc;
          inst_d.alu_res   = exu_alu_res;
          inst_d.reg_wen   = exu_inst_reg_wen;
          inst_d.reg_waddr = exu_inst_reg_waddr;
          inst_d.mem2reg   = exu_inst_mem2reg;
          inst_d.is_store  = exu_inst_mem_wen;
          inst_d.mem_op    = exu_inst_mem_op;
          if (is_mem && !acc_misalign) begin
            state_d  = ST_REQ;
            req_d    = 1'b1;
            we_d     = exu_inst_mem_wen;
            addr_d   = {exu_alu_res[CPU_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
            be_d     = st_be;
            bwdata_d = st_wdata;
          end else begin
            // non-memory ops and dropped accesses retire straight from the latch
            done_d     = 1'b1;
            mis_d      = is_mem;
            wb_pc_d    = exu_inst_pc;
            wb_waddr_d = exu_inst_reg_waddr;
            wb_wdata_d = exu_alu_res;
            wb_wen_d   = !is_mem && exu_inst_reg_wen && (exu_inst_reg_waddr != '0);
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (inst_q.is_store) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            wb_pc_d    = inst_q.pc;
            wb_waddr_d = inst_q.reg_waddr;
            wb_wdata_d = inst_q.alu_res;
            wb_wen_d   = 1'b0;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (dmem_rvalid) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          wb_pc_d    = inst_q.pc;
          wb_waddr_d = inst_q.reg_waddr;
          wb_wdata_d = inst_q.mem2reg ? ld_data : inst_q.alu_res;
          wb_wen_d   = inst_q.reg_wen && (inst_q.reg_waddr != '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      inst_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      bwdata_q   <= '0;
      be_q       <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      busy_q     <= 1'b0;
      wb_pc_q    <= '0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bwdata_q   <= bwdata_d;
      be_q       <= be_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      busy_q     <= busy_d;
      wb_pc_q    <= wb_pc_d;
      wb_wen_q   <= wb_wen_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = bwdata_q;
  assign dmem_be       = be_q;
  assign mem_done_en   = done_q;
  assign mem_inst_pc   = wb_pc_q;
  assign mem_reg_wen   = wb_wen_q;
  assign mem_reg_waddr = wb_waddr_q;
  assign mem_reg_wdata = wb_wdata_q;
  assign mem_misalign  = mis_q;
  assign mem_busy      = busy_q;

endmodule
